// File: rtl/nios_core_pio_in_irq.sv
// -----------------------------------------------------------------------------
// nios_core_pio_in_irq
//
// Avalon-MM input PIO slave with edge-capture interrupts. A WIDTH-bit external
// input bus is brought into the clk domain through a two-flop synchroniser,
// optionally debounced per bit, and edge-detected. Detected edges latch into a
// sticky capture register that the CPU clears 1-to-clear. Captured bits that
// are enabled in the interrupt mask raise a level interrupt.
//
// Register map (word offsets):
//   0 DATA    RO  debounced stable input value
//   1 -       RO  reads 0
//   2 IRQMASK RW  per-bit interrupt enable
//   3 EDGECAP RW1C captured edges
//
// Parameters:
//   WIDTH           input bus width, 1..32 (unused readdata bits read 0)
//   EDGE_TYPE       0 rising, 1 falling, 2 any edge
//   DEBOUNCE_CYCLES stability required in clocks, 0 disables the filter
//   RESET_VALUE     reset value of the synchroniser/stable/previous registers
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe (no wait states)
//   writedata  write data
//   in_port    asynchronous external inputs
//   readdata   registered read data, valid one cycle after address
//   irq        level interrupt, active high, driven from flops only
// -----------------------------------------------------------------------------
module nios_core_pio_in_irq #(
    parameter int unsigned      WIDTH           = 16,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter int unsigned      DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] clr_w;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             wr_en;

    // Upper writedata bits beyond WIDTH have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // ---- Stage: two-flop synchroniser ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // ---- Stage: debounce filter ----
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            assign stable_d = sync2_q;
        end else begin : g_db
            localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [CNT_W-1:0] cnt_d [WIDTH];

            // A bit's counter only runs while the synchronised input disagrees
            // with the accepted value; any return to agreement restarts it, so
            // a glitch must persist DEBOUNCE_CYCLES+1 cycles to be accepted.
            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt_d[i] = '0;
                    if (sync2_q[i] != stable_q[i]) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            stable_d[i] = sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end
        end
    endgenerate

    // ---- Stage: edge detect and capture ----
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_w = stable_q & ~prev_q;
            1:       edge_w = ~stable_q & prev_q;
            default: edge_w = stable_q ^ prev_q;
        endcase
    end

    assign clr_w  = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // Set has priority: an edge arriving with a clear keeps the bit.
    assign cap_d  = edge_w | (cap_q & ~clr_w);
    assign mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

    always_comb begin
        rdata_d = '0;
        case (address)
            2'd0:    rdata_d[WIDTH-1:0] = stable_q;
            2'd2:    rdata_d[WIDTH-1:0] = mask_q;
            2'd3:    rdata_d[WIDTH-1:0] = cap_q;
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= RESET_VALUE;
            prev_q   <= RESET_VALUE;
            mask_q   <= '0;
            cap_q    <= '0;
            rdata_q  <= '0;
        end else begin
            stable_q <= stable_d;
            prev_q   <= stable_q;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
        end
    end

    // ---- Stage: outputs (flop-driven only) ----
    assign readdata = rdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_core_pio_in_irq.sv
module tb_nios_core_pio_in_irq;

    localparam int DA = 0;  // WIDTH 16, rising, no debounce
    localparam int DB = 1;  // WIDTH 16, any edge, debounce 4
    localparam int DC = 2;  // WIDTH 8, falling, no debounce, reset value A5
    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;

    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] exp;
        string       name;
        int          due;
    } chk_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        cs = 1'b0;
    logic        wn = 1'b1;
    logic [31:0] wd = '0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [7:0]  in_c = 8'hA5;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    chk_t sb[$];
    int   ncnt = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nios_core_pio_in_irq #(.WIDTH(16), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .RESET_VALUE(16'h0000)) u_a (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

    nios_core_pio_in_irq #(.WIDTH(16), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(16'h0000)) u_b (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .in_port(in_b), .readdata(rd_b), .irq(irq_b));

    nios_core_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(0), .RESET_VALUE(8'hA5)) u_c (
        .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wn),
        .writedata(wd), .in_port(in_c), .readdata(rd_c), .irq(irq_c));

    // Posedge counter: each expectation is due at the negedge after a given edge.
    always @(posedge clk) ncnt <= ncnt + 1;

    // Monitor: pops due expectations and compares against the DUT outputs.
    chk_t        it;
    logic [31:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= ncnt) begin
            it = sb.pop_front();
            case (it.dut)
                DA:      act = (it.kind == K_RD) ? rd_a : {31'd0, irq_a};
                DB:      act = (it.kind == K_RD) ? rd_b : {31'd0, irq_b};
                default: act = (it.kind == K_RD) ? rd_c : {31'd0, irq_c};
            endcase
            n_chk = n_chk + 1;
            if (act !== it.exp) begin
                n_err = n_err + 1;
                $display("FAIL %s (dut %0d): got 0x%08h expected 0x%08h", it.name, it.dut, act, it.exp);
            end
        end
    end

    task automatic push(input int dut, input int kind, input logic [31:0] exp,
                        input string name, input int due);
        chk_t c;
        c.dut = dut; c.kind = kind; c.exp = exp; c.name = name; c.due = due;
        sb.push_back(c);
    endtask

    task automatic bus_idle();
        cs = 1'b0; wn = 1'b1; addr = 2'd0; wd = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        cs = 1'b1; wn = 1'b1; addr = a; wd = '0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wn = 1'b0; addr = a; wd = d;
    endtask

    task automatic tick(input int n);
        bus_idle();
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_wr(a, d);
        @(negedge clk);
        bus_idle();
    endtask

    // Expectation evaluated just after the next rising edge.
    task automatic step_chk(input int dut, input int kind, input logic [31:0] exp, input string name);
        push(dut, kind, exp, name, ncnt + 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        step_chk(DA, K_IRQ, 0, "rst_irq_a");
        bus_rd(2'd0);
        step_chk(DA, K_RD, 0, "rst_rd_a");
        reset_n = 1'b1;
        tick(2);
        for (int a = 0; a < 4; a++) begin
            bus_rd(a[1:0]);
            step_chk(DA, K_RD, 0, $sformatf("rst_off%0d", a));
        end
        bus_rd(2'd0);
        step_chk(DC, K_RD, 32'h0000_00A5, "c_rst_data");
        bus_rd(2'd3);
        step_chk(DC, K_RD, 0, "c_rst_cap");
        step_chk(DC, K_IRQ, 0, "c_rst_irq");

        // No debounce, rising edge
        wr(2'd2, 32'h1);
        in_a = 16'h0001;
        tick(2);
        step_chk(DA, K_IRQ, 0, "a_irq_e2");
        step_chk(DA, K_IRQ, 1, "a_irq_e3");
        bus_rd(2'd3);
        step_chk(DA, K_RD, 1, "a_cap");
        bus_rd(2'd0);
        step_chk(DA, K_RD, 1, "a_data");
        bus_wr(2'd3, 32'h1);
        step_chk(DA, K_IRQ, 0, "a_irq_clr");

        // Clear coinciding with a new edge: set wins
        in_a = 16'h0000; tick(4);
        in_a = 16'h0001; tick(5);
        step_chk(DA, K_IRQ, 1, "a_irq_set2");
        in_a = 16'h0000; tick(4);
        in_a = 16'h0001; tick(3);
        bus_wr(2'd3, 32'h1);
        step_chk(DA, K_IRQ, 1, "simul_irq");
        bus_rd(2'd3);
        step_chk(DA, K_RD, 1, "simul_cap");
        bus_wr(2'd3, 32'h1);
        step_chk(DA, K_IRQ, 0, "simul_clr");

        // Mask behaviour
        in_a = 16'h0000; tick(4);
        in_a = 16'h0003; tick(5);
        bus_wr(2'd2, 32'h2);
        step_chk(DA, K_IRQ, 1, "mask2_irq");
        bus_wr(2'd2, 32'h4);
        step_chk(DA, K_IRQ, 0, "mask4_irq");
        bus_wr(2'd2, 32'h0);
        step_chk(DA, K_IRQ, 0, "mask0_irq");
        bus_rd(2'd3);
        step_chk(DA, K_RD, 3, "cap3");
        bus_rd(2'd2);
        step_chk(DA, K_RD, 0, "mask_rd");
        wr(2'd3, 32'hFFFF);

        // Debounce 4: short pulse rejected
        in_b = 16'h0004; tick(3);
        in_b = 16'h0000; tick(8);
        bus_rd(2'd0);
        step_chk(DB, K_RD, 0, "db_pulse_data");
        bus_rd(2'd3);
        step_chk(DB, K_RD, 0, "db_pulse_cap");

        // Debounce 4: long level accepted at E0+6, captured at E0+7
        in_b = 16'h0004; tick(6);
        bus_rd(2'd0);
        step_chk(DB, K_RD, 0, "db_data_pre");
        bus_rd(2'd0);
        step_chk(DB, K_RD, 32'h4, "db_data_e6");
        bus_rd(2'd3);
        step_chk(DB, K_RD, 32'h4, "db_cap_e7");
        tick(2);
        wr(2'd3, 32'hFFFF);
        in_b = 16'h0000; tick(10);
        wr(2'd3, 32'hFFFF);

        // Any-edge capture on bit 5
        in_b = 16'h0020; tick(20);
        bus_rd(2'd3);
        step_chk(DB, K_RD, 32'h20, "any_rise");
        bus_rd(2'd0);
        step_chk(DB, K_RD, 32'h20, "any_data");
        wr(2'd3, 32'h20);
        bus_rd(2'd3);
        step_chk(DB, K_RD, 0, "any_clr");
        in_b = 16'h0000; tick(20);
        bus_rd(2'd3);
        step_chk(DB, K_RD, 32'h20, "any_fall");
        wr(2'd3, 32'hFFFF);

        // Narrow instance: falling edge, upper bits read 0
        wr(2'd2, 32'hFFFF_FFFF);
        bus_rd(2'd2);
        step_chk(DC, K_RD, 32'hFF, "c_mask_rd");
        in_c = 8'hA4; tick(5);
        step_chk(DC, K_IRQ, 1, "c_fall_irq");
        bus_rd(2'd3);
        step_chk(DC, K_RD, 32'h1, "c_fall_cap");
        bus_rd(2'd0);
        step_chk(DC, K_RD, 32'hA4, "c_data");
        wr(2'd3, 32'h1);
        in_c = 8'hA5; tick(5);
        bus_rd(2'd3);
        step_chk(DC, K_RD, 0, "c_rise_nocap");
        step_chk(DC, K_IRQ, 0, "c_irq_low");

        // Mid-operation asynchronous reset
        wr(2'd2, 32'hFFFF);
        in_a = 16'h0000; tick(4);
        in_a = 16'h0003; tick(5);
        step_chk(DA, K_IRQ, 1, "pre_rst_irq");
        in_b = 16'h0004; tick(4);
        in_a = 16'h0000;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        push(DA, K_RD, 0, "rst_async_rd", ncnt);
        push(DA, K_IRQ, 0, "rst_async_irq", ncnt);
        @(negedge clk);
        in_b = 16'h0000;
        tick(2);
        reset_n = 1'b1;
        tick(12);
        bus_rd(2'd3);
        step_chk(DB, K_RD, 0, "post_rst_cap_b");
        bus_rd(2'd0);
        step_chk(DB, K_RD, 0, "post_rst_data_b");
        bus_rd(2'd3);
        step_chk(DA, K_RD, 0, "post_rst_cap_a");
        bus_rd(2'd2);
        step_chk(DA, K_RD, 0, "post_rst_mask_a");
        step_chk(DB, K_IRQ, 0, "post_rst_irq_b");
        tick(3);

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            n_err = n_err + sb.size();
            n_chk = n_chk + sb.size();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/nios_core_pio_in_irq.md
# nios_core_pio_in_irq

Parametrised Avalon-MM input PIO slave for the NIOS core. It samples a WIDTH-bit external input bus (switches, keys) through a two-flop synchroniser and an optional per-bit debounce filter. Each bit has rising, falling or any-edge capture, a per-bit interrupt mask and a level interrupt to the CPU. It replaces the plain input-only switch port, which has no synchronisation, debounce or interrupts.

## Interface
- WIDTH, 16, input bus width, 1..32; unused readdata bits read 0
- EDGE_TYPE, 0, capture condition: 0 rising, 1 falling, 2 any edge
- DEBOUNCE_CYCLES, 0, required stability in clocks (0 = filter off), 0..65535
- RESET_VALUE, 0, reset value of synchroniser, stable and previous-stable registers (WIDTH bits)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active high

## Operation
- Register map (word offsets):
  - 0 DATA: RO, debounced stable value; writes ignored.
  - 1 reserved: reads 0.
  - 2 IRQMASK: RW, WIDTH bits.
  - 3 EDGECAP: read returns captured edges; write is 1-to-clear per bit.
- Write occurs on a clk edge with chipselect=1 and write_n=0. No wait states.
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
  - DEBOUNCE_CYCLES=0: stable <= sync2 every cycle.
  - Otherwise, while sync2 == stable: cnt <= 0.
  - While sync2 != stable and cnt < DEBOUNCE_CYCLES: cnt <= cnt+1.
  - When sync2 != stable and cnt == DEBOUNCE_CYCLES: stable <= sync2, cnt <= 0.
  - A pulse shorter than DEBOUNCE_CYCLES+1 cycles at sync2 never reaches stable.
- Edge detect: prev <= stable every cycle. Edge condition per EDGE_TYPE:
  - rising: stable & ~prev
  - falling: ~stable & prev
  - any: stable ^ prev
- Edge capture: cap[i] <= edge[i] | (cap[i] & ~clr[i]).
  - clr = writedata[WIDTH-1:0] on a write to offset 3, else 0.
  - A new edge in the same cycle as a clear leaves the bit set (set wins).
- irq = |(cap & IRQMASK), driven combinationally from flops only; no input-to-output combinational path.
- readdata <= mux(address) on every clk edge regardless of chipselect, zero-extended to 32 bits.

## Timing
- Reset values:
  - readdata 0, irq 0, IRQMASK 0, EDGECAP 0, all debounce counters 0.
  - sync1, sync2, stable and prev = RESET_VALUE, so no edges are captured out of reset.
- Read latency 1: readdata is valid the cycle after address is presented.
- in_port change sampled at edge E0:
  - stable updates at E0+2+DEBOUNCE_CYCLES.
  - EDGECAP bit and irq set at E0+3+DEBOUNCE_CYCLES.
  - DATA readable from readdata after E0+3+DEBOUNCE_CYCLES.
- IRQMASK write at edge W takes effect on irq immediately after W.
- EDGECAP clear at edge W drops irq after W unless another edge sets the bit in the same cycle.
- Reset asserted mid-debounce or mid-capture clears all state asynchronously. After release, operation resumes from RESET_VALUE with no spurious capture.
- Input held through reset at a value ≠ RESET_VALUE produces an edge after release; this is intended.

## Test plan
- Reset: WIDTH=16, RESET_VALUE=0, in_port=0x0000.
  - Release reset -> readdata=0, irq=0.
  - Read offsets 0..3 all return 0x00000000.
- No debounce, rising edge: set IRQMASK=0x0001, drive in_port=0x0001 at E0.
  - irq=1 after E0+3; offset 3 reads 0x1; offset 0 reads 0x1.
  - Write 0x1 to offset 3 -> irq=0 the next cycle.
- Debounce DEBOUNCE_CYCLES=4:
  - 3-cycle pulse on bit 2 -> DATA stays 0, EDGECAP stays 0.
  - 10-cycle level on bit 2 -> DATA=0x4 at E0+6, EDGECAP=0x4 at E0+7.
- EDGE_TYPE=2, toggle bit 5 high then low 20 cycles apart with a clear in between -> EDGECAP bit 5 set after each transition.
- Simultaneous events: issue a clear of bit 0 in the same cycle a new rising edge on bit 0 is detected -> EDGECAP[0] remains 1 and irq stays high.
- Mask and mid-operation reset:
  - EDGECAP=0x3 with IRQMASK=0x2 -> irq=1; IRQMASK=0 -> irq=0.
  - Assert reset_n=0 mid-debounce -> all outputs 0 immediately and no capture after release with in_port=RESET_VALUE.
